// File: rtl/eth_txbuf_pkg.sv
// Shared types and constants for the Ethernet TX buffer drain path.
package eth_txbuf_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int BYTE_IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } txrd_state_e;

endpackage

// File: rtl/eth_txbuf_wordq.sv
// Two-entry word FIFO between the RAM wide port and the byte serialiser.
module eth_txbuf_wordq #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eth_txbuf_reader.sv
// Drains a frame from the buffer RAM wide port and serialises it onto an 8-bit AXI-Stream.
//   state | meaning
//   IDLE  | waiting for start_i, word queue held flushed
//   RUN   | fetching words and streaming bytes
//   DONE  | one-cycle done_o pulse, then back to IDLE
module eth_txbuf_reader
  import eth_txbuf_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [63:0]       mem_rdata_i,
  output logic [7:0]        m_axis_tdata_o,
  output logic              m_axis_tvalid_o,
  output logic              m_axis_tlast_o,
  input  logic              m_axis_tready_i
);

  localparam int WCNT_W = LEN_W - BYTE_IDX_W + 1;

  txrd_state_e state, state_nxt;

  logic [ADDR_W-1:0]     addr;
  logic [WCNT_W-1:0]     words_left;
  logic [WCNT_W-1:0]     words_init;
  logic [LEN_W:0]        len_rnd;
  logic [LEN_W-1:0]      bytes_left;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic                  rd_pending;
  logic                  start_ok;
  logic                  hs;
  logic                  last_hs;
  logic                  pop;
  logic                  q_room;
  logic [63:0]           q_head;
  logic                  q_full;
  logic                  q_empty;
  logic [1:0]            q_count;

  assign len_rnd    = {1'b0, len_i} + (LEN_W+1)'(BYTES_PER_WORD - 1);
  assign words_init = len_rnd[LEN_W:BYTE_IDX_W];

  assign start_ok = (state == IDLE) && start_i;
  assign hs       = m_axis_tvalid_o && m_axis_tready_i;
  assign last_hs  = hs && (bytes_left == LEN_W'(1));
  // The final word may be partial, so it is released on the last byte rather than byte 7.
  assign pop      = hs && (last_hs || (&byte_idx));

  // A read in flight already owns a queue slot.
  assign q_room     = ({1'b0, q_count} + {2'b00, rd_pending}) < 3'd2;
  assign mem_en_o   = (state == RUN) && (words_left != '0) && q_room;
  assign mem_addr_o = addr;

  assign m_axis_tvalid_o = (state == RUN) && !q_empty;
  assign m_axis_tdata_o  = m_axis_tvalid_o ? q_head[{byte_idx, 3'b000} +: 8] : 8'h00;
  assign m_axis_tlast_o  = m_axis_tvalid_o && (bytes_left == LEN_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = (state != IDLE);
    done_o    = (state == DONE);
    case (state)
      IDLE:    if (start_i) state_nxt = (len_i == '0) ? DONE : RUN;
      RUN:     if (last_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr       <= '0;
      words_left <= '0;
      bytes_left <= '0;
      byte_idx   <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= mem_en_o;
      if (start_ok) begin
        addr       <= base_i;
        words_left <= words_init;
        bytes_left <= len_i;
        byte_idx   <= '0;
      end else begin
        if (mem_en_o) begin
          addr       <= addr + ADDR_W'(1);
          words_left <= words_left - WCNT_W'(1);
        end
        if (hs) begin
          bytes_left <= bytes_left - LEN_W'(1);
          byte_idx   <= byte_idx + BYTE_IDX_W'(1);
        end
      end
    end
  end

  eth_txbuf_wordq #(.W(64)) u_wordq (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (state == IDLE),
    .push   (rd_pending),
    .wdata  (mem_rdata_i),
    .pop    (pop),
    .rdata  (q_head),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

endmodule

// File: tb/tb_eth_txbuf_reader.sv
// Directed bench for eth_txbuf_reader against a 1-cycle-latency RAM model.
module tb_eth_txbuf_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] base = '0;
  logic [13:0] len = '0;
  logic        busy, done, mem_en;
  logic [10:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  logic [7:0]  tdata;
  logic        tvalid, tlast;
  logic        tready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [10:0] rd_q[$];
  logic [7:0]  byte_q[$];
  int          beat_cyc[$];
  int          tlast_n, tlast_beat, done_cyc, en_first, busy_n, stall_err, max_buf;

  always #5 clk = ~clk;

  eth_txbuf_reader dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .base_i          (base),
    .len_i           (len),
    .busy_o          (busy),
    .done_o          (done),
    .mem_en_o        (mem_en),
    .mem_addr_o      (mem_addr),
    .mem_rdata_i     (mem_rdata),
    .m_axis_tdata_o  (tdata),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tlast_o  (tlast),
    .m_axis_tready_i (tready)
  );

  function automatic logic [63:0] ram_word(input logic [10:0] a);
    return {8{a[7:0]}} + 64'h0706050403020100;
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= ram_word(mem_addr);

  function automatic logic [7:0] exp_byte(input logic [10:0] b, input int j);
    logic [10:0] a;
    logic [63:0] w;
    a = b + 11'(j / 8);
    w = ram_word(a);
    return w[8*(j%8) +: 8];
  endfunction

  function automatic logic pick_ready(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  function automatic int first_beat();
    return (beat_cyc.size() > 0) ? beat_cyc[0] : -1;
  endfunction

  function automatic int last_beat();
    return (beat_cyc.size() > 0) ? beat_cyc[beat_cyc.size()-1] : -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_stream(input string tag, input logic [10:0] b, input int l);
    chk({tag, "_nbytes"}, byte_q.size(), l);
    for (int j = 0; j < byte_q.size(); j++) chk({tag, "_byte"}, byte_q[j], exp_byte(b, j));
  endtask

  // Cycle 0 is the cycle start is driven; poke_at re-pulses start mid-frame with other values.
  task automatic run_frame(input logic [10:0] b, input logic [13:0] l, input int rdy_pct,
                           input int abort_at, input int poke_at);
    int   cyc;
    int   issued;
    logic prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    rd_q.delete(); byte_q.delete(); beat_cyc.delete();
    tlast_n = 0; tlast_beat = -1; done_cyc = -1; en_first = -1; busy_n = 0;
    stall_err = 0; max_buf = 0; issued = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l; tready = pick_ready(rdy_pct);
    cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (mem_en) begin
        rd_q.push_back(mem_addr);
        issued++;
        if (en_first < 0) en_first = cyc;
        if (issued - byte_q.size() / 8 > max_buf) max_buf = issued - byte_q.size() / 8;
      end
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stall_err++;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (tvalid && tready) begin
        byte_q.push_back(tdata);
        beat_cyc.push_back(cyc);
        if (tlast) begin
          tlast_n++;
          tlast_beat = byte_q.size();
        end
      end
      if (busy) busy_n++;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (abort_at > 0 && byte_q.size() == abort_at) begin
        chk("abort_no_done_yet", done_cyc < 0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_tvalid", tvalid, 0);
        chk("abort_tlast", tlast, 0);
        chk("abort_tdata", tdata, 0);
        @(negedge clk);
        chk("abort_hold_mem_en", mem_en, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_after_mem_en", mem_en, 0);
        chk("abort_after_done", done, 0);
        return;
      end
      if (done_cyc >= 0) break;
      @(posedge clk); #1;
      cyc++;
      start = (cyc == poke_at);
      if (start) begin
        base = b + 11'd100;
        len  = 14'd3;
      end
      tready = pick_ready(rdy_pct);
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 20 bytes from word 0, MAC always ready
    run_frame(11'd0, 14'd20, 100, 0, -1);
    chk_stream("a", 11'd0, 20);
    chk("a_first_en", en_first, 1);
    chk("a_first_beat", first_beat(), 3);
    chk("a_last_beat", last_beat(), 22);
    chk("a_reads", rd_q.size(), 3);
    for (int i = 0; i < rd_q.size(); i++) chk("a_read_addr", rd_q[i], i);
    chk("a_tlast_n", tlast_n, 1);
    chk("a_tlast_beat", tlast_beat, 20);
    chk("a_done_cyc", done_cyc, 23);

    run_frame(11'd0, 14'd1, 100, 0, -1);
    chk_stream("b", 11'd0, 1);
    chk("b_tlast_beat", tlast_beat, 1);
    chk("b_reads", rd_q.size(), 1);
    chk("b_busy_cycles", busy_n, 4);
    chk("b_done_cyc", done_cyc, 4);

    run_frame(11'd0, 14'd0, 100, 0, -1);
    chk("c_reads", rd_q.size(), 0);
    chk("c_beats", byte_q.size(), 0);
    chk("c_done_cyc", done_cyc, 1);

    // address wrap 2047 -> 0
    run_frame(11'd2047, 14'd16, 100, 0, -1);
    chk_stream("d", 11'd2047, 16);
    chk("d_reads", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      chk("d_addr0", rd_q[0], 11'd2047);
      chk("d_addr1", rd_q[1], 11'd0);
    end
    chk("d_first_beat", first_beat(), 3);
    chk("d_last_beat", last_beat(), 18);
    chk("d_tlast_beat", tlast_beat, 16);

    // back-pressure: MAC ready ~70% of cycles
    run_frame(11'd3, 14'd64, 70, 0, -1);
    chk_stream("e", 11'd3, 64);
    chk("e_stall_stable", stall_err, 0);
    chk("e_max_buf_le2", max_buf <= 2, 1'b1);
    chk("e_reads", rd_q.size(), 8);
    chk("e_tlast_n", tlast_n, 1);
    chk("e_tlast_beat", tlast_beat, 64);

    // reset after beat 5, then a clean 8-byte frame with a stray start mid-frame
    run_frame(11'd5, 14'd40, 100, 5, -1);
    run_frame(11'd8, 14'd8, 100, 0, 4);
    chk_stream("f", 11'd8, 8);
    chk("f_reads", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("f_addr", rd_q[0], 11'd8);
    chk("f_tlast_beat", tlast_beat, 8);
    chk("f_done_cyc", done_cyc, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
